// File: rtl/relu_max_pool_if.sv
// Bus between the ReLU/max-pool engine and the shared RAM: start/done control plus
// the single-outstanding memory request handshake.
interface relu_max_pool_if;
  logic        enable;
  logic        mem_opdone;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [31:0] addr_o;
  logic [1:0]  mem_operation;
  logic        done;

  modport master (
    input  enable, mem_opdone, data_i,
    output data_o, addr_o, mem_operation, done
  );

  modport slave (
    output enable, mem_opdone, data_i,
    input  data_o, addr_o, mem_operation, done
  );
endinterface

// File: rtl/relu_max_pool.sv
// ReLU + POOLxPOOL max-pooling over the convolution result held in shared RAM;
// the pooled matrix is written directly after the result matrix.
module relu_max_pool #(
  parameter int POOL = 2,
  parameter bit RELU = 1'b1
) (
  input logic              clk,
  input logic              reset,
  relu_max_pool_if.master  bus
);

  typedef enum logic [2:0] {IDLE, FETCH, CALC, WIN_INIT, RD, STEP, WR, NEXT} state_t;

  localparam logic [1:0]  OP_NONE  = 2'b00;
  localparam logic [1:0]  OP_RD    = 2'b01;
  localparam logic [1:0]  OP_WR    = 2'b11;
  localparam logic [31:0] POOL_U   = 32'(POOL);
  localparam logic [3:0]  WIN_LAST = 4'(POOL - 1);
  localparam logic signed [31:0] MAX_INIT = RELU ? 32'sh0000_0000 : 32'sh8000_0000;

  state_t      state_q, state_d;
  logic        last_enable_q, last_enable_d;
  logic [1:0]  mem_op_q, mem_op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic [1:0]  fidx_q, fidx_d;

  logic [31:0] w_q, w_d, h_q, h_d, fw_q, fw_d, fh_q, fh_d;
  logic [31:0] rw_q, rw_d, rh_q, rh_d, br_q, br_d, bp_q, bp_d, pw_q, pw_d, ph_q, ph_d;
  logic [31:0] r_q, r_d, c_q, c_d;
  logic [3:0]  a_q, a_d, b_q, b_d;
  logic signed [31:0] max_q, max_d;

  logic [31:0] rw_c, rh_c, br_c, bp_c, rd_addr_c, wr_addr_c;

  assign rw_c = w_q - fw_q + 32'd1;
  assign rh_c = h_q - fh_q + 32'd1;
  assign br_c = 32'd4 + 32'd2 * h_q * w_q + fh_q * fw_q;
  assign bp_c = br_c + rh_c * rw_c;
  assign rd_addr_c = br_q + (POOL_U * r_q + 32'(a_q)) * rw_q + POOL_U * c_q + 32'(b_q);
  assign wr_addr_c = bp_q + r_q * pw_q + c_q;

  assign bus.data_o        = data_q;
  assign bus.addr_o        = addr_q;
  assign bus.mem_operation = mem_op_q;
  assign bus.done          = done_q;

  always_comb begin
    state_d       = state_q;
    last_enable_d = last_enable_q;
    mem_op_d      = mem_op_q;
    addr_d        = addr_q;
    data_d        = data_q;
    done_d        = done_q;
    fidx_d        = fidx_q;
    w_d = w_q;  h_d = h_q;  fw_d = fw_q;  fh_d = fh_q;
    rw_d = rw_q; rh_d = rh_q; br_d = br_q; bp_d = bp_q; pw_d = pw_q; ph_d = ph_q;
    r_d = r_q;  c_d = c_q;  a_d = a_q;  b_d = b_q;
    max_d = max_q;

    case (state_q)
      IDLE: begin
        done_d        = 1'b1;
        last_enable_d = bus.enable;
        if (bus.enable && !last_enable_q) begin
          state_d = FETCH;
          done_d  = 1'b0;
          fidx_d  = 2'd0;
        end
      end
      // A request is issued only while the bus is quiet, which also guarantees the
      // idle cycle that must follow every completed access.
      FETCH: begin
        if (mem_op_q == OP_NONE) begin
          mem_op_d = OP_RD;
          addr_d   = 32'(fidx_q);
        end else if (bus.mem_opdone) begin
          mem_op_d = OP_NONE;
          case (fidx_q)
            2'd0:    w_d  = bus.data_i;
            2'd1:    h_d  = bus.data_i;
            2'd2:    fw_d = bus.data_i;
            default: fh_d = bus.data_i;
          endcase
          fidx_d = fidx_q + 2'd1;
          if (fidx_q == 2'd3) state_d = CALC;
        end
      end
      CALC: begin
        rw_d = rw_c;
        rh_d = rh_c;
        br_d = br_c;
        bp_d = bp_c;
        pw_d = rw_c / POOL_U;
        ph_d = rh_c / POOL_U;
        if ($signed(rw_c) < POOL || $signed(rh_c) < POOL) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          r_d     = 32'd0;
          c_d     = 32'd0;
          state_d = WIN_INIT;
        end
      end
      WIN_INIT: begin
        max_d   = MAX_INIT;
        a_d     = 4'd0;
        b_d     = 4'd0;
        state_d = RD;
      end
      RD: begin
        if (mem_op_q == OP_NONE) begin
          mem_op_d = OP_RD;
          addr_d   = rd_addr_c;
        end else if (bus.mem_opdone) begin
          mem_op_d = OP_NONE;
          if ($signed(bus.data_i) > max_q) max_d = $signed(bus.data_i);
          state_d = STEP;
        end
      end
      STEP: begin
        state_d = RD;
        if (b_q == WIN_LAST) begin
          b_d = 4'd0;
          if (a_q == WIN_LAST) state_d = WR;
          else                 a_d = a_q + 4'd1;
        end else begin
          b_d = b_q + 4'd1;
        end
      end
      WR: begin
        if (mem_op_q == OP_NONE) begin
          mem_op_d = OP_WR;
          addr_d   = wr_addr_c;
          data_d   = max_q;
        end else if (bus.mem_opdone) begin
          mem_op_d = OP_NONE;
          state_d  = NEXT;
        end
      end
      NEXT: begin
        state_d = WIN_INIT;
        if (c_q == pw_q - 32'd1) begin
          c_d = 32'd0;
          if (r_q == ph_q - 32'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            r_d = r_q + 32'd1;
          end
        end else begin
          c_d = c_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      last_enable_q <= 1'b0;
      mem_op_q      <= OP_NONE;
      addr_q        <= 32'd0;
      data_q        <= 32'd0;
      done_q        <= 1'b0;
      fidx_q        <= 2'd0;
    end else begin
      state_q       <= state_d;
      last_enable_q <= last_enable_d;
      mem_op_q      <= mem_op_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      done_q        <= done_d;
      fidx_q        <= fidx_d;
    end
  end

  // Geometry, window indices and the running max carry no reset: every run
  // reloads them before use.
  always_ff @(posedge clk) begin
    w_q  <= w_d;   h_q  <= h_d;   fw_q <= fw_d;  fh_q <= fh_d;
    rw_q <= rw_d;  rh_q <= rh_d;  br_q <= br_d;  bp_q <= bp_d;
    pw_q <= pw_d;  ph_q <= ph_d;
    r_q  <= r_d;   c_q  <= c_d;   a_q  <= a_d;   b_q  <= b_d;
    max_q <= max_d;
  end

endmodule

// File: tb/tb_relu_max_pool.sv
// Scoreboard bench: two engines (RELU=1 and RELU=0) share clock/reset, each has its own
// RAM model; expected writes are queued by stimulus and popped when a write completes.
module tb_relu_max_pool;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   dly;

  relu_max_pool_if bus0 ();
  relu_max_pool_if bus1 ();

  relu_max_pool #(.POOL(2), .RELU(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  relu_max_pool #(.POOL(2), .RELU(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  logic [31:0] ram [2][128];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  int          cnt [2];
  logic [31:0] hold_addr [2];
  logic [31:0] hold_data [2];
  logic [1:0]  hold_op [2];
  int          reads0 [2];
  int          last_prm [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic [31:0] a, input logic [31:0] v);
    if (d == 0) q0.push_back({a, v});
    else        q1.push_back({a, v});
  endtask

  // RAM responder and write monitor for one engine.
  task automatic ram_step(input int d, input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic opd_in, input logic [31:0] rd_in,
                          output logic opd_out, output logic [31:0] rd_out);
    logic [63:0] e;
    opd_out = opd_in;
    rd_out  = rd_in;
    if (reset || opd_in || op == 2'b00) begin
      opd_out = 1'b0;
      cnt[d]  = 0;
    end else begin
      if (cnt[d] == 0) begin
        hold_addr[d] = addr; hold_data[d] = wd; hold_op[d] = op;
      end else begin
        check("hold_addr", addr, hold_addr[d]);
        check("hold_op", {30'd0, op}, {30'd0, hold_op[d]});
        if (op == 2'b11) check("hold_data", wd, hold_data[d]);
      end
      if (cnt[d] >= dly) begin
        opd_out = 1'b1;
        if (op == 2'b01) begin
          rd_out = ram[d][addr[6:0]];
          if (addr == 32'd0) reads0[d]++;
          if (addr == 32'd3) last_prm[d] = cyc;
        end else begin
          ram[d][addr[6:0]] = wd;
          if (d == 0 && q0.size() > 0)      e = q0.pop_front();
          else if (d == 1 && q1.size() > 0) e = q1.pop_front();
          else begin
            e = {addr, wd};
            check("unexpected_write", 32'd1, 32'd0);
          end
          check($sformatf("wr_addr%0d", d), addr, e[63:32]);
          check($sformatf("wr_data%0d", d), wd, e[31:0]);
        end
      end else begin
        cnt[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    logic        o_opd;
    logic [31:0] o_rd;
    ram_step(0, bus0.mem_operation, bus0.addr_o, bus0.data_o, bus0.mem_opdone, bus0.data_i, o_opd, o_rd);
    bus0.mem_opdone = o_opd;
    bus0.data_i     = o_rd;
    ram_step(1, bus1.mem_operation, bus1.addr_o, bus1.data_o, bus1.mem_opdone, bus1.data_i, o_opd, o_rd);
    bus1.mem_opdone = o_opd;
    bus1.data_i     = o_rd;
  end

  task automatic load(input int w, input int h, input int fw, input int fh);
    for (int d = 0; d < 2; d++) begin
      ram[d][0] = 32'(w); ram[d][1] = 32'(h); ram[d][2] = 32'(fw); ram[d][3] = 32'(fh);
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] v);
    ram[0][a] = v;
    ram[1][a] = v;
  endtask

  task automatic set_en(input logic v);
    bus0.enable = v;
    bus1.enable = v;
  endtask

  task automatic run_both(input int hold, output int done_cyc);
    int t;
    set_en(1'b1);
    t = 0;
    while ((bus0.done || bus1.done) && t < 20) begin @(negedge clk); t++; end
    check("start_seen", 32'(t < 20), 32'd1);
    t = 0;
    while (!(bus0.done && bus1.done) && t < 5000) begin @(negedge clk); t++; end
    check("run_complete", 32'(t < 5000), 32'd1);
    done_cyc = cyc;
    repeat (hold) @(negedge clk);
    set_en(1'b0);
    @(negedge clk);
  endtask

  task automatic check_drained(input string name);
    check({name, "_q0_left"}, 32'(q0.size()), 32'd0);
    check({name, "_q1_left"}, 32'(q1.size()), 32'd0);
    q0.delete();
    q1.delete();
  endtask

  task automatic setup_t1();
    load(5, 5, 2, 2);
    for (int i = 0; i < 16; i++) set_word(58 + i, 32'(i + 1));
    for (int d = 0; d < 2; d++) begin
      push(d, 32'd74, 32'd6);  push(d, 32'd75, 32'd8);
      push(d, 32'd76, 32'd14); push(d, 32'd77, 32'd16);
    end
  endtask

  task automatic setup_t3();
    logic [31:0] vals [9] = '{32'd9, 32'd1, 32'd7, 32'd2, 32'd3, 32'd4, 32'd8, 32'd8, 32'd8};
    load(4, 4, 2, 2);
    for (int i = 0; i < 9; i++) set_word(40 + i, vals[i]);
  endtask

  initial begin
    int dc;
    int rb;
    int t;
    n_cmp = 0; n_fail = 0; cyc = 0; dly = 0;
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0; reads0[d] = 0; last_prm[d] = 0;
      for (int i = 0; i < 128; i++) ram[d][i] = 32'd0;
    end
    reset = 1'b1;
    set_en(1'b0);
    bus0.mem_opdone = 1'b0; bus0.data_i = 32'd0;
    bus1.mem_opdone = 1'b0; bus1.data_i = 32'd0;
    repeat (3) @(negedge clk);

    check("rst_data_o", bus0.data_o, 32'd0);
    check("rst_addr_o", bus0.addr_o, 32'd0);
    check("rst_mem_op", {30'd0, bus0.mem_operation}, 32'd0);
    check("rst_done", {31'd0, bus0.done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("done_after_rst", {31'd0, bus0.done}, 32'd1);
    check("done_after_rst1", {31'd0, bus1.done}, 32'd1);

    // T1: 4x4 result 1..16, pooled 6/8/14/16 at 74..77
    setup_t1();
    run_both(0, dc);
    check_drained("t1");

    // T2: all -5; ReLU clamps to 0, plain max keeps -5
    for (int i = 0; i < 16; i++) set_word(58 + i, 32'hFFFF_FFFB);
    for (int i = 0; i < 4; i++) begin
      push(0, 32'(74 + i), 32'd0);
      push(1, 32'(74 + i), 32'hFFFF_FFFB);
    end
    run_both(0, dc);
    check_drained("t2");

    // T3: 3x3 result, single window -> 9 at 49
    setup_t3();
    push(0, 32'd49, 32'd9);
    push(1, 32'd49, 32'd9);
    run_both(0, dc);
    check_drained("t3");

    // T4: RW=0 -> no writes, quick return to idle
    load(5, 5, 6, 2);
    run_both(0, dc);
    check("t4_done_latency", 32'(dc - last_prm[0] <= 7), 32'd1);
    check("t4_mem_op_idle", {30'd0, bus0.mem_operation}, 32'd0);
    check_drained("t4");

    // T5: slow memory, same results as T1
    dly = 3;
    setup_t1();
    run_both(0, dc);
    check_drained("t5");

    // Reset asserted during a window read
    load(5, 5, 2, 2);
    set_en(1'b1);
    t = 0;
    while (!(bus0.mem_operation == 2'b01 && bus0.addr_o >= 32'd58) && t < 300) begin
      @(negedge clk); t++;
    end
    check("rd_reached", 32'(t < 300), 32'd1);
    set_en(1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_mem_op", {30'd0, bus0.mem_operation}, 32'd0);
    check("abort_addr", bus0.addr_o, 32'd0);
    check("abort_done", {31'd0, bus0.done}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_done_rise", {31'd0, bus0.done}, 32'd1);
    dly = 0;
    check_drained("abort");

    // T6: enable held high gives one run only; a fresh 0->1 edge gives exactly one more
    setup_t3();
    push(0, 32'd49, 32'd9);
    push(1, 32'd49, 32'd9);
    rb = reads0[0];
    run_both(20, dc);
    check("t6_one_run", 32'(reads0[0] - rb), 32'd1);
    check_drained("t6a");
    push(0, 32'd49, 32'd9);
    push(1, 32'd49, 32'd9);
    run_both(0, dc);
    check("t6_second_run", 32'(reads0[0] - rb), 32'd2);
    check("t6_done", {31'd0, bus0.done}, 32'd1);
    check_drained("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
